// File: rtl/ex_stage.sv
// Execute stage: EX pipeline register, ALU, data-SRAM request, iterative
// restoring divider for DIV/DIVU, and the EX->MEM / EX->ID buses.
module ex_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   stall,
    input  logic [158:0] id_to_ex_bus,
    output logic [140:0] ex_to_mem_bus,
    output logic [37:0]  ex_to_id_bus,
    output logic         ex_is_load,
    output logic         stallreq_for_ex,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_wen,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata
);

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // alu_op bit positions (one-hot)
    localparam int OP_ADD  = 11;
    localparam int OP_SUB  = 10;
    localparam int OP_SLT  = 9;
    localparam int OP_SLTU = 8;
    localparam int OP_AND  = 7;
    localparam int OP_NOR  = 6;
    localparam int OP_OR   = 5;
    localparam int OP_XOR  = 4;
    localparam int OP_SLL  = 3;
    localparam int OP_SRL  = 2;
    localparam int OP_SRA  = 1;
    localparam int OP_LUI  = 0;

    localparam logic [5:0] FUNC_DIV  = 6'h1A;
    localparam logic [5:0] FUNC_DIVU = 6'h1B;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  sel_alu_src1;
        logic [3:0]  sel_alu_src2;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
        logic        hilo_we;
        logic [31:0] hi;
        logic [31:0] lo;
    } ex_mem_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    id_ex_t ex_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_q <= '0;
        end else if (stall[2] == STOP && stall[3] == NO_STOP) begin
            ex_q <= '0;
        end else if (stall[2] == NO_STOP) begin
            ex_q <= id_to_ex_bus;
        end
    end

    logic ex_holds;
    assign ex_holds = (stall[2] == STOP) && (stall[3] == STOP);

    // Operand selection: one-hot AND-OR, all-zero select gives zero.
    logic [31:0] imm_sext, imm_zext, sa_zext;
    logic [31:0] src1, src2;

    assign imm_sext = {{16{ex_q.inst[15]}}, ex_q.inst[15:0]};
    assign imm_zext = {16'b0, ex_q.inst[15:0]};
    assign sa_zext  = {27'b0, ex_q.inst[10:6]};

    assign src1 = ({32{ex_q.sel_alu_src1[0]}} & ex_q.rs_val)
                | ({32{ex_q.sel_alu_src1[1]}} & ex_q.pc)
                | ({32{ex_q.sel_alu_src1[2]}} & sa_zext);

    assign src2 = ({32{ex_q.sel_alu_src2[0]}} & ex_q.rt_val)
                | ({32{ex_q.sel_alu_src2[1]}} & imm_sext)
                | ({32{ex_q.sel_alu_src2[2]}} & 32'd8)
                | ({32{ex_q.sel_alu_src2[3]}} & imm_zext);

    logic [4:0]  shamt;
    logic [31:0] add_res, sub_res, slt_res, sltu_res, and_res, nor_res;
    logic [31:0] or_res, xor_res, sll_res, srl_res, sra_res, lui_res;
    logic [31:0] alu_result;

    assign shamt    = src1[4:0];
    assign add_res  = src1 + src2;
    assign sub_res  = src1 - src2;
    assign slt_res  = {31'b0, $signed(src1) < $signed(src2)};
    assign sltu_res = {31'b0, src1 < src2};
    assign and_res  = src1 & src2;
    assign nor_res  = ~(src1 | src2);
    assign or_res   = src1 | src2;
    assign xor_res  = src1 ^ src2;
    assign sll_res  = src2 << shamt;
    assign srl_res  = src2 >> shamt;
    assign sra_res  = $unsigned($signed(src2) >>> shamt);
    assign lui_res  = {src2[15:0], 16'b0};

    assign alu_result = ({32{ex_q.alu_op[OP_ADD]}}  & add_res)
                      | ({32{ex_q.alu_op[OP_SUB]}}  & sub_res)
                      | ({32{ex_q.alu_op[OP_SLT]}}  & slt_res)
                      | ({32{ex_q.alu_op[OP_SLTU]}} & sltu_res)
                      | ({32{ex_q.alu_op[OP_AND]}}  & and_res)
                      | ({32{ex_q.alu_op[OP_NOR]}}  & nor_res)
                      | ({32{ex_q.alu_op[OP_OR]}}   & or_res)
                      | ({32{ex_q.alu_op[OP_XOR]}}  & xor_res)
                      | ({32{ex_q.alu_op[OP_SLL]}}  & sll_res)
                      | ({32{ex_q.alu_op[OP_SRL]}}  & srl_res)
                      | ({32{ex_q.alu_op[OP_SRA]}}  & sra_res)
                      | ({32{ex_q.alu_op[OP_LUI]}}  & lui_res);

    // Divider decode and operand magnitudes
    logic        is_div, is_divu, div_req;
    logic [31:0] rs_abs, rt_abs;

    assign is_div  = (ex_q.inst[31:26] == 6'd0) && (ex_q.inst[5:0] == FUNC_DIV);
    assign is_divu = (ex_q.inst[31:26] == 6'd0) && (ex_q.inst[5:0] == FUNC_DIVU);
    assign div_req = is_div || is_divu;
    assign rs_abs  = (is_div && ex_q.rs_val[31]) ? (32'd0 - ex_q.rs_val) : ex_q.rs_val;
    assign rt_abs  = (is_div && ex_q.rt_val[31]) ? (32'd0 - ex_q.rt_val) : ex_q.rt_val;

    div_state_t  div_state;
    logic [4:0]  div_cnt;
    logic [31:0] quo_q, rem_q, dsor_q;
    logic        quo_neg_q, rem_neg_q, dsor_zero_q;

    // One restoring step: shift the next dividend bit into the partial remainder.
    logic [32:0] rem_shift, rem_sub;
    logic        rem_ge;

    assign rem_shift = {rem_q, quo_q[31]};
    assign rem_sub   = rem_shift - {1'b0, dsor_q};
    assign rem_ge    = rem_shift >= {1'b0, dsor_q};

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_state   <= DIV_IDLE;
            div_cnt     <= 5'd0;
            quo_q       <= 32'd0;
            rem_q       <= 32'd0;
            dsor_q      <= 32'd0;
            quo_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
            dsor_zero_q <= 1'b0;
        end else begin
            case (div_state)
                DIV_IDLE: begin
                    if (div_req) begin
                        div_state   <= DIV_BUSY;
                        div_cnt     <= 5'd0;
                        quo_q       <= rs_abs;
                        rem_q       <= 32'd0;
                        dsor_q      <= rt_abs;
                        quo_neg_q   <= is_div && (ex_q.rs_val[31] ^ ex_q.rt_val[31]);
                        rem_neg_q   <= is_div && ex_q.rs_val[31];
                        dsor_zero_q <= (ex_q.rt_val == 32'd0);
                    end
                end
                DIV_BUSY: begin
                    quo_q   <= {quo_q[30:0], rem_ge};
                    rem_q   <= rem_ge ? rem_sub[31:0] : rem_shift[31:0];
                    div_cnt <= div_cnt + 5'd1;
                    if (div_cnt == 5'd31) begin
                        div_state <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    // The div leaves EX on either a capture or a bubble.
                    if (!ex_holds) begin
                        div_state <= DIV_IDLE;
                    end
                end
                default: div_state <= DIV_IDLE;
            endcase
        end
    end

    logic        hilo_we;
    logic [31:0] quo_signed, rem_signed;

    assign hilo_we    = (div_state == DIV_DONE);
    assign quo_signed = quo_neg_q ? (32'd0 - quo_q) : quo_q;
    assign rem_signed = rem_neg_q ? (32'd0 - rem_q) : rem_q;

    assign stallreq_for_ex = ((div_state == DIV_IDLE) && div_req) || (div_state == DIV_BUSY);

    ex_mem_t mem_bus;

    always_comb begin
        mem_bus              = '0;
        mem_bus.pc           = ex_q.pc;
        mem_bus.data_ram_en  = ex_q.data_ram_en;
        mem_bus.data_ram_wen = ex_q.data_ram_wen;
        mem_bus.sel_rf_res   = ex_q.sel_rf_res;
        mem_bus.rf_we        = ex_q.rf_we;
        mem_bus.rf_waddr     = ex_q.rf_waddr;
        mem_bus.ex_result    = alu_result;
        mem_bus.hilo_we      = hilo_we;
        if (hilo_we) begin
            mem_bus.hi = rem_signed;
            mem_bus.lo = dsor_zero_q ? 32'hFFFF_FFFF : quo_signed;
        end
    end

    assign ex_to_mem_bus   = mem_bus;
    assign ex_to_id_bus    = {ex_q.rf_we, ex_q.rf_waddr, alu_result};
    assign ex_is_load      = ex_q.data_ram_en && (ex_q.data_ram_wen == 4'd0);
    assign data_sram_en    = ex_q.data_ram_en;
    assign data_sram_wen   = ex_q.data_ram_en ? ex_q.data_ram_wen : 4'd0;
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = ex_q.rt_val;

    logic unused_bits;
    assign unused_bits = ^{ex_q.inst[25:16], stall[5:4], stall[1:0], rem_sub[32]};

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: ALU, memory requests, divider timing,
// reset during a divide, and stall/bubble behaviour in DONE.
module tb_ex_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic [158:0] id_to_ex_bus;
    logic [140:0] ex_to_mem_bus;
    logic [37:0]  ex_to_id_bus;
    logic         ex_is_load;
    logic         stallreq_for_ex;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    logic         ctrl_auto;
    logic [5:0]   stall_force;
    int           n_checks = 0;
    int           n_fail   = 0;

    localparam logic [11:0] A_ADD  = 12'b1000_0000_0000;
    localparam logic [11:0] A_SUB  = 12'b0100_0000_0000;
    localparam logic [11:0] A_SLT  = 12'b0010_0000_0000;
    localparam logic [11:0] A_SLTU = 12'b0001_0000_0000;
    localparam logic [11:0] A_AND  = 12'b0000_1000_0000;
    localparam logic [11:0] A_NOR  = 12'b0000_0100_0000;
    localparam logic [11:0] A_OR   = 12'b0000_0010_0000;
    localparam logic [11:0] A_XOR  = 12'b0000_0001_0000;
    localparam logic [11:0] A_SLL  = 12'b0000_0000_1000;
    localparam logic [11:0] A_SRL  = 12'b0000_0000_0100;
    localparam logic [11:0] A_SRA  = 12'b0000_0000_0010;
    localparam logic [11:0] A_LUI  = 12'b0000_0000_0001;

    ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .id_to_ex_bus    (id_to_ex_bus),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .ex_to_id_bus    (ex_to_id_bus),
        .ex_is_load      (ex_is_load),
        .stallreq_for_ex (stallreq_for_ex),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    always #5 clk = ~clk;

    // Stall controller: EX holds and MEM bubbles while the divider is busy.
    assign stall = ctrl_auto ? (stallreq_for_ex ? 6'b001111 : 6'b000000) : stall_force;

    function automatic logic [158:0] make_bus(
        input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] op,
        input logic [2:0] s1, input logic [3:0] s2, input logic en, input logic [3:0] wen,
        input logic we, input logic [4:0] waddr, input logic sel_res,
        input logic [31:0] rs, input logic [31:0] rt);
        return {pc, inst, op, s1, s2, en, wen, we, waddr, sel_res, rs, rt};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts consecutive cycles with stallreq_for_ex high, starting in the current cycle.
    task automatic count_stall(output int cycles);
        cycles = 0;
        while (stallreq_for_ex && cycles < 200) begin
            cycles++;
            step();
        end
    endtask

    task automatic test_reset();
        ctrl_auto    = 1'b1;
        stall_force  = 6'b0;
        rst          = 1'b0;
        id_to_ex_bus = make_bus(32'hBFC0_0000, 32'h2489_FFFF, A_ADD, 3'b001, 4'b0010,
                                1'b1, 4'hF, 1'b1, 5'd9, 1'b0, 32'd5, 32'd7);
        repeat (2) step();
        n_checks++;
        if ({ex_to_mem_bus, ex_to_id_bus, ex_is_load, stallreq_for_ex, data_sram_en,
             data_sram_wen, data_sram_addr, data_sram_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got mem=%h id=%h load=%b sreq=%b en=%b wen=%h addr=%h wdata=%h, expected all zero",
                     ex_to_mem_bus, ex_to_id_bus, ex_is_load, stallreq_for_ex, data_sram_en,
                     data_sram_wen, data_sram_addr, data_sram_wdata);
        end
        n_checks++;
        if (dut.div_state !== 2'd0 || dut.div_cnt !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_fsm: got state=%0d cnt=%0d, expected 0/0", dut.div_state, dut.div_cnt);
        end
        id_to_ex_bus = '0;
        rst = 1'b1;
        step();
    endtask

    task automatic test_addiu();
        id_to_ex_bus = make_bus(32'hBFC0_0000, 32'h2489_FFFF, A_ADD, 3'b001, 4'b0010,
                                1'b0, 4'h0, 1'b1, 5'd9, 1'b0, 32'd5, 32'd0);
        step();
        n_checks++;
        if (ex_to_id_bus !== {1'b1, 5'd9, 32'd4}) begin
            n_fail++;
            $display("FAIL addiu_fwd: got %h, expected %h", ex_to_id_bus, {1'b1, 5'd9, 32'd4});
        end
        n_checks++;
        if (ex_to_mem_bus !== {32'hBFC0_0000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9, 32'd4, 1'b0, 64'd0}) begin
            n_fail++;
            $display("FAIL addiu_mem_bus: got %h", ex_to_mem_bus);
        end
    endtask

    task automatic test_alu();
        logic [158:0] vbus [14];
        logic [31:0]  vres [14];
        vbus[0]  = make_bus(32'h0, 32'h0, A_SUB,  3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'd10, 32'd3);
        vres[0]  = 32'd7;
        vbus[1]  = make_bus(32'h0, 32'h0, A_SLT,  3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'hFFFF_FFFF, 32'd1);
        vres[1]  = 32'd1;
        vbus[2]  = make_bus(32'h0, 32'h0, A_SLTU, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'hFFFF_FFFF, 32'd1);
        vres[2]  = 32'd0;
        vbus[3]  = make_bus(32'h0, 32'h0, A_AND,  3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00);
        vres[3]  = 32'hF000_F000;
        vbus[4]  = make_bus(32'h0, 32'h0, A_NOR,  3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'hF0F0_F0F0, 32'h0F0F_0F00);
        vres[4]  = 32'h0000_000F;
        vbus[5]  = make_bus(32'h0, 32'h0, A_XOR,  3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'h1234, 32'h00FF);
        vres[5]  = 32'h12CB;
        vbus[6]  = make_bus(32'h0, 32'h3400_8000, A_OR, 3'b001, 4'b1000, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'h1, 32'h0);
        vres[6]  = 32'h8001;
        vbus[7]  = make_bus(32'h0, 32'h0000_0100, A_SLL, 3'b100, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'h0, 32'h1);
        vres[7]  = 32'h10;
        vbus[8]  = make_bus(32'h0, 32'h0, A_SRL,  3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'h28, 32'h8000_0000);
        vres[8]  = 32'h0080_0000;
        vbus[9]  = make_bus(32'h0, 32'h0, A_SRA,  3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'h28, 32'h8000_0000);
        vres[9]  = 32'hFF80_0000;
        vbus[10] = make_bus(32'h0, 32'h3C09_1234, A_LUI, 3'b000, 4'b1000, 1'b0, 4'h0, 1'b1, 5'd9, 1'b0, 32'h0, 32'h0);
        vres[10] = 32'h1234_0000;
        vbus[11] = make_bus(32'hBFC0_0100, 32'h0, A_ADD, 3'b010, 4'b0100, 1'b0, 4'h0, 1'b1, 5'd31, 1'b0, 32'h0, 32'h0);
        vres[11] = 32'hBFC0_0108;
        vbus[12] = make_bus(32'h0, 32'h0, A_ADD,  3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'h7FFF_FFFF, 32'd1);
        vres[12] = 32'h8000_0000;
        vbus[13] = make_bus(32'h0, 32'h0, 12'd0,  3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'd5, 32'd5);
        vres[13] = 32'd0;
        for (int i = 0; i < 14; i++) begin
            id_to_ex_bus = vbus[i];
            step();
            n_checks++;
            if (ex_to_mem_bus[96:65] !== vres[i]) begin
                n_fail++;
                $display("FAIL alu_vec%0d: got %h, expected %h", i, ex_to_mem_bus[96:65], vres[i]);
            end
        end
    endtask

    task automatic test_mem();
        id_to_ex_bus = make_bus(32'h0, 32'h8C89_0008, A_ADD, 3'b001, 4'b0010, 1'b1, 4'h0,
                                1'b1, 5'd9, 1'b1, 32'h1000, 32'h5555_5555);
        step();
        n_checks++;
        if ({data_sram_en, data_sram_wen, data_sram_addr, ex_is_load} !== {1'b1, 4'h0, 32'h1008, 1'b1}) begin
            n_fail++;
            $display("FAIL lw_request: got en=%b wen=%h addr=%h load=%b, expected 1/0/00001008/1",
                     data_sram_en, data_sram_wen, data_sram_addr, ex_is_load);
        end
        n_checks++;
        if ({ex_to_mem_bus[108], ex_to_mem_bus[103]} !== 2'b11) begin
            n_fail++;
            $display("FAIL lw_bus_flags: got en=%b sel_res=%b, expected 1/1", ex_to_mem_bus[108], ex_to_mem_bus[103]);
        end
        id_to_ex_bus = make_bus(32'h0, 32'hAC89_0004, A_ADD, 3'b001, 4'b0010, 1'b1, 4'hF,
                                1'b0, 5'd0, 1'b0, 32'h2000, 32'hDEAD_BEEF);
        step();
        n_checks++;
        if ({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, ex_is_load}
                !== {1'b1, 4'hF, 32'h2004, 32'hDEAD_BEEF, 1'b0}) begin
            n_fail++;
            $display("FAIL sw_request: got en=%b wen=%h addr=%h wdata=%h load=%b, expected 1/F/00002004/DEADBEEF/0",
                     data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, ex_is_load);
        end
        id_to_ex_bus = make_bus(32'h0, 32'h0, A_ADD, 3'b001, 4'b0001, 1'b0, 4'hF,
                                1'b0, 5'd0, 1'b0, 32'h10, 32'h20);
        step();
        n_checks++;
        if ({data_sram_en, data_sram_wen, ex_is_load} !== {1'b0, 4'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL wen_gated: got en=%b wen=%h load=%b, expected 0/0/0", data_sram_en, data_sram_wen, ex_is_load);
        end
    endtask

    // Runs one divide to DONE and checks latency and result; leaves the bench in the DONE cycle.
    task automatic run_div(input string tag, input logic [31:0] inst, input logic [31:0] rs,
                           input logic [31:0] rt, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int cycles;
        id_to_ex_bus = make_bus(32'hBFC0_0200, inst, 12'd0, 3'b000, 4'b0000, 1'b0, 4'h0,
                                1'b0, 5'd0, 1'b0, rs, rt);
        step();
        id_to_ex_bus = '0;
        count_stall(cycles);
        n_checks++;
        if (cycles !== 33) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d stall cycles, expected 33", tag, cycles);
        end
        n_checks++;
        if ({ex_to_mem_bus[140:109], ex_to_mem_bus[64:0]} !== {32'hBFC0_0200, 1'b1, exp_hi, exp_lo}) begin
            n_fail++;
            $display("FAIL %s_result: got pc=%h we=%b hi=%h lo=%h, expected pc=bfc00200 we=1 hi=%h lo=%h", tag,
                     ex_to_mem_bus[140:109], ex_to_mem_bus[64], ex_to_mem_bus[63:32], ex_to_mem_bus[31:0],
                     exp_hi, exp_lo);
        end
    endtask

    task automatic test_div();
        run_div("div_neg7_2", 32'h0085_001A, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        step();
        n_checks++;
        if (ex_to_mem_bus[64:0] !== 65'd0) begin
            n_fail++;
            $display("FAIL div_one_cycle: got we=%b hi=%h lo=%h after DONE, expected all zero",
                     ex_to_mem_bus[64], ex_to_mem_bus[63:32], ex_to_mem_bus[31:0]);
        end
    endtask

    task automatic test_divu_zero_and_reset();
        run_div("divu_by_zero", 32'h0085_001B, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100);
        step();
        id_to_ex_bus = make_bus(32'hBFC0_0200, 32'h0085_001B, 12'd0, 3'b000, 4'b0000, 1'b0, 4'h0,
                                1'b0, 5'd0, 1'b0, 32'd50, 32'd3);
        step();
        id_to_ex_bus = '0;
        repeat (10) step();
        rst = 1'b0;
        step();
        n_checks++;
        if (stallreq_for_ex !== 1'b0 || dut.div_state !== 2'd0 || dut.div_cnt !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_mid_busy: got sreq=%b state=%0d cnt=%0d, expected 0/0/0",
                     stallreq_for_ex, dut.div_state, dut.div_cnt);
        end
        rst = 1'b1;
        step();
        run_div("divu_after_reset", 32'h0085_001B, 32'd50, 32'd3, 32'd16, 32'd2);
        step();
    endtask

    task automatic test_back_to_back();
        int cycles;
        id_to_ex_bus = make_bus(32'hBFC0_0200, 32'h0085_001A, 12'd0, 3'b000, 4'b0000, 1'b0, 4'h0,
                                1'b0, 5'd0, 1'b0, 32'd7, 32'hFFFF_FFFE);
        step();
        id_to_ex_bus = make_bus(32'hBFC0_0204, 32'h0085_001B, 12'd0, 3'b000, 4'b0000, 1'b0, 4'h0,
                                1'b0, 5'd0, 1'b0, 32'hFFFF_FFFF, 32'h10);
        count_stall(cycles);
        n_checks++;
        if (cycles !== 33 || ex_to_mem_bus[31:0] !== 32'hFFFF_FFFD || ex_to_mem_bus[63:32] !== 32'd1) begin
            n_fail++;
            $display("FAIL b2b_first: got cycles=%0d lo=%h hi=%h, expected 33/fffffffd/00000001",
                     cycles, ex_to_mem_bus[31:0], ex_to_mem_bus[63:32]);
        end
        step();
        id_to_ex_bus = '0;
        count_stall(cycles);
        n_checks++;
        if (cycles !== 33 || ex_to_mem_bus[140:109] !== 32'hBFC0_0204 || ex_to_mem_bus[64:0] !== {1'b1, 32'hF, 32'h0FFF_FFFF}) begin
            n_fail++;
            $display("FAIL b2b_second: got cycles=%0d pc=%h we=%b hi=%h lo=%h, expected 33/bfc00204/1/0000000f/0fffffff",
                     cycles, ex_to_mem_bus[140:109], ex_to_mem_bus[64], ex_to_mem_bus[63:32], ex_to_mem_bus[31:0]);
        end
        step();
    endtask

    task automatic test_stall_bubble();
        run_div("div_7_neg2", 32'h0085_001A, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        ctrl_auto   = 1'b0;
        stall_force = 6'b001111;
        step();
        n_checks++;
        if ({ex_to_mem_bus[140:109], ex_to_mem_bus[64:0], stallreq_for_ex}
                !== {32'hBFC0_0200, 1'b1, 32'd1, 32'hFFFF_FFFD, 1'b0}) begin
            n_fail++;
            $display("FAIL done_hold: got pc=%h we=%b hi=%h lo=%h sreq=%b, expected bfc00200/1/00000001/fffffffd/0",
                     ex_to_mem_bus[140:109], ex_to_mem_bus[64], ex_to_mem_bus[63:32], ex_to_mem_bus[31:0],
                     stallreq_for_ex);
        end
        stall_force = 6'b000111;
        step();
        n_checks++;
        if (ex_to_mem_bus !== '0 || stallreq_for_ex !== 1'b0 || dut.div_state !== 2'd0) begin
            n_fail++;
            $display("FAIL done_bubble: got mem=%h sreq=%b state=%0d, expected 0/0/0",
                     ex_to_mem_bus, stallreq_for_ex, dut.div_state);
        end
        ctrl_auto = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_addiu();
        test_alu();
        test_mem();
        test_div();
        test_divu_zero_and_reset();
        test_back_to_back();
        test_stall_bubble();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
